// File: rtl/fall_ctrl.sv
// fall_ctrl: gravity/lock controller for the active falling piece.
// Latency: tick -> chk_req one cycle later; ack -> row update one cycle later.
// Backpressure: holds chk_req/chk_row until chk_ack; ticks arriving meanwhile are dropped.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   tick                one-cycle fall-step pulse
//   spawn               new-piece request (accepted only when idle)
//   chk_req/chk_row     collision query to the playfield checker
//   chk_ack/chk_hit     checker response (ignored unless chk_req=1)
//   row, active         current piece row and in-play flag
//   lock                one-cycle pulse when the piece is committed
//   game_over           sticky spawn-collision flag
module fall_ctrl #(
  parameter int ROWS       = 20,
  parameter int ROW_W      = 5,
  parameter int SPAWN_ROW  = 0,
  parameter int LOCK_TICKS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             spawn,
  output logic             chk_req,
  output logic [ROW_W-1:0] chk_row,
  input  logic             chk_ack,
  input  logic             chk_hit,
  output logic [ROW_W-1:0] row,
  output logic             active,
  output logic             lock,
  output logic             game_over
);

  typedef enum logic [2:0] {
    IDLE,
    SPAWN_CHK,
    FALLING,
    FALL_CHK,
    GROUNDED,
    GND_CHK,
    LOCK,
    OVER
  } state_t;

  localparam logic [ROW_W-1:0] FLOOR   = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] SPAWN_R = ROW_W'(SPAWN_ROW);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_TICKS);

  state_t           state;
  logic [3:0]       ground_cnt;
  logic             at_floor;
  logic [ROW_W-1:0] row_next;
  logic [3:0]       cnt_inc;
  logic             cnt_done;
  logic             ack;

  // row_next is only consumed when the piece is above the floor, so it never
  // produces a query beyond the last legal row.
  assign at_floor = (row == FLOOR);
  assign row_next = row + ROW_W'(1);
  // Saturating grounded-step count; reaching LOCK_TICKS always leaves GROUNDED,
  // so saturation only matters as a guard against wrap.
  assign cnt_inc  = (ground_cnt == 4'hF) ? ground_cnt : ground_cnt + 4'd1;
  assign cnt_done = (cnt_inc == LOCK_N);
  // A response only counts while a query is outstanding.
  assign ack      = chk_req & chk_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      chk_row    <= '0;
      chk_req    <= 1'b0;
      active     <= 1'b0;
      lock       <= 1'b0;
      game_over  <= 1'b0;
      ground_cnt <= '0;
    end else begin
      lock <= 1'b0;
      case (state)
        IDLE: begin
          if (spawn) begin
            state   <= SPAWN_CHK;
            chk_req <= 1'b1;
            chk_row <= SPAWN_R;
          end
        end

        SPAWN_CHK: begin
          if (ack) begin
            chk_req <= 1'b0;
            if (chk_hit) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state      <= FALLING;
              row        <= SPAWN_R;
              active     <= 1'b1;
              ground_cnt <= '0;
            end
          end
        end

        FALLING: begin
          if (tick) begin
            if (at_floor) begin
              // Resting on the floor: first grounded step, nothing to ask.
              ground_cnt <= 4'd1;
              if (LOCK_N == 4'd1) begin
                state <= LOCK;
                lock  <= 1'b1;
              end else begin
                state <= GROUNDED;
              end
            end else begin
              state   <= FALL_CHK;
              chk_req <= 1'b1;
              chk_row <= row_next;
            end
          end
        end

        FALL_CHK: begin
          if (ack) begin
            chk_req <= 1'b0;
            if (!chk_hit) begin
              state <= FALLING;
              row   <= row_next;
            end else begin
              ground_cnt <= 4'd1;
              if (LOCK_N == 4'd1) begin
                state <= LOCK;
                lock  <= 1'b1;
              end else begin
                state <= GROUNDED;
              end
            end
          end
        end

        GROUNDED: begin
          if (tick) begin
            if (at_floor) begin
              ground_cnt <= cnt_inc;
              if (cnt_done) begin
                state <= LOCK;
                lock  <= 1'b1;
              end
            end else begin
              // Re-ask: a lateral move may have opened the cell below.
              state   <= GND_CHK;
              chk_req <= 1'b1;
              chk_row <= row_next;
            end
          end
        end

        GND_CHK: begin
          if (ack) begin
            chk_req <= 1'b0;
            if (!chk_hit) begin
              state      <= FALLING;
              row        <= row_next;
              ground_cnt <= '0;
            end else begin
              ground_cnt <= cnt_inc;
              if (cnt_done) begin
                state <= LOCK;
                lock  <= 1'b1;
              end else begin
                state <= GROUNDED;
              end
            end
          end
        end

        // lock is high for this single cycle; row keeps the final value.
        LOCK: begin
          state  <= IDLE;
          active <= 1'b0;
        end

        OVER: begin
          state <= OVER;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fall_ctrl.sv
// Bench for fall_ctrl: directed scenarios with literal expectations, then
// randomized tick/spawn/checker traffic compared every cycle against a
// piece-level reference model; a second instance covers LOCK_TICKS=1.
module tb_fall_ctrl;
  localparam int ROWS      = 20;
  localparam int ROW_W     = 5;
  localparam int SPAWN_ROW = 0;
  localparam int LT        = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic             reset, tick, spawn, chk_ack, chk_hit;
  logic             chk_req, active, lock, game_over;
  logic [ROW_W-1:0] chk_row, row;

  // LOCK_TICKS=1 instance
  logic             r1, tk1, sp1, ak1, ht1;
  logic             req1, act1, lock1, go1;
  logic [ROW_W-1:0] crow1, row1;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  fall_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W), .SPAWN_ROW(SPAWN_ROW), .LOCK_TICKS(LT)) dut (
    .clk(clk), .reset(reset), .tick(tick), .spawn(spawn),
    .chk_req(chk_req), .chk_row(chk_row), .chk_ack(chk_ack), .chk_hit(chk_hit),
    .row(row), .active(active), .lock(lock), .game_over(game_over)
  );

  fall_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W), .SPAWN_ROW(SPAWN_ROW), .LOCK_TICKS(1)) dut1 (
    .clk(clk), .reset(r1), .tick(tk1), .spawn(sp1),
    .chk_req(req1), .chk_row(crow1), .chk_ack(ak1), .chk_hit(ht1),
    .row(row1), .active(act1), .lock(lock1), .game_over(go1)
  );

  // ---------------- reference model (piece-level view) ----------------
  // m_req: a query is outstanding; m_spawnq: that query is a spawn check;
  // m_cnt: consecutive grounded steps; m_lock: this is the lock cycle.
  logic             m_req = 1'b0, m_spawnq = 1'b0, m_active = 1'b0;
  logic             m_lock = 1'b0, m_over = 1'b0;
  logic [ROW_W-1:0] m_row = '0, m_qrow = '0;
  int               m_cnt = 0;

  task grounded_step();
    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    if (m_cnt >= LT) m_lock = 1'b1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_req = 0; m_spawnq = 0; m_active = 0; m_lock = 0; m_over = 0;
      m_row = '0; m_qrow = '0; m_cnt = 0;
    end else if (m_over) begin
      // nothing moves until reset
    end else if (m_lock) begin
      m_lock = 1'b0;
      m_active = 1'b0;
    end else if (m_req) begin
      if (chk_ack) begin
        m_req = 1'b0;
        if (m_spawnq) begin
          if (chk_hit) m_over = 1'b1;
          else begin
            m_row = ROW_W'(SPAWN_ROW); m_active = 1'b1; m_cnt = 0;
          end
        end else if (!chk_hit) begin
          m_row = ROW_W'(int'(m_row) + 1);
          m_cnt = 0;
        end else begin
          grounded_step();
        end
      end
    end else if (!m_active) begin
      if (spawn) begin
        m_req = 1'b1; m_spawnq = 1'b1; m_qrow = ROW_W'(SPAWN_ROW);
      end
    end else if (tick) begin
      if (int'(m_row) == ROWS - 1) grounded_step();
      else begin
        m_req = 1'b1; m_spawnq = 1'b0; m_qrow = ROW_W'(int'(m_row) + 1);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (chk_req !== m_req || chk_row !== m_qrow || row !== m_row ||
          active !== m_active || lock !== m_lock || game_over !== m_over) begin
        errors++;
        $display("FAIL model_cmp t=%0t got req=%b crow=%0d row=%0d act=%b lock=%b go=%b want req=%b crow=%0d row=%0d act=%b lock=%b go=%b",
                 $time, chk_req, chk_row, row, active, lock, game_over,
                 m_req, m_qrow, m_row, m_active, m_lock, m_over);
      end
      if (chk_req === 1'b1) begin
        checks++;
        if (int'(chk_row) > ROWS - 1) begin
          errors++;
          $display("FAIL chk_row_range got %0d max %0d", chk_row, ROWS - 1);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // one tick, then enough idle cycles for an immediate ack to be absorbed
  task automatic tick_pulse();
    tick = 1'b1; cyc(); tick = 1'b0; cyc(); cyc();
  endtask

  task automatic do_spawn();
    spawn = 1'b1; cyc(); spawn = 1'b0; cyc();
  endtask

  int hp;
  int seen;

  initial begin
    reset = 1'b1; tick = 0; spawn = 0; chk_ack = 0; chk_hit = 0;
    r1 = 1'b1; tk1 = 0; sp1 = 0; ak1 = 0; ht1 = 0;
    cyc(); cyc();
    cmp_en = 1'b1;
    check("rst_req", chk_req, 0);
    check("rst_row", row, 0);
    check("rst_active", active, 0);
    check("rst_lock", lock, 0);
    check("rst_game_over", game_over, 0);
    reset = 1'b0;
    r1 = 1'b0;

    // 1: fall to the floor, two grounded steps, lock
    chk_ack = 1; chk_hit = 0;
    do_spawn();
    check("spawn_active", active, 1);
    check("spawn_row", row, 0);
    for (int i = 0; i < 19; i++) tick_pulse();
    check("floor_row", row, 19);
    tick = 1; cyc(); tick = 0;
    check("floor_no_query", chk_req, 0);
    check("floor_no_lock", lock, 0);
    cyc();
    tick = 1; cyc(); tick = 0;
    check("floor_lock", lock, 1);
    cyc();
    check("lock_one_cycle", lock, 0);
    check("lock_inactive", active, 0);

    // 2: spawn collides -> sticky game over
    chk_hit = 1;
    do_spawn();
    check("over_flag", game_over, 1);
    check("over_inactive", active, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      spawn = i[0]; tick = ~i[0];
      cyc();
      if (chk_req === 1'b1) seen++;
    end
    spawn = 0; tick = 0;
    check("over_no_query", seen, 0);
    check("over_sticky", game_over, 1);
    reset = 1; cyc(); reset = 0;
    check("over_cleared", game_over, 0);

    // 3a: grounded at row 5, re-query hit -> lock
    chk_hit = 0;
    do_spawn();
    for (int i = 0; i < 5; i++) tick_pulse();
    check("row5", row, 5);
    chk_hit = 1;
    tick_pulse();
    check("gnd_row", row, 5);
    check("gnd_no_lock", lock, 0);
    tick = 1; cyc(); tick = 0;
    check("gnd_query_row", chk_row, 6);
    cyc();
    check("gnd_lock", lock, 1);
    check("gnd_lock_row", row, 5);
    cyc();

    // 3b: grounded, re-query clear -> resumes falling
    chk_hit = 0;
    do_spawn();
    for (int i = 0; i < 5; i++) tick_pulse();
    chk_hit = 1;
    tick_pulse();
    chk_hit = 0;
    tick_pulse();
    check("freed_row", row, 6);
    check("freed_no_lock", lock, 0);
    tick_pulse();
    check("resume_row", row, 7);

    // 4: slow checker, extra ticks dropped
    chk_ack = 0;
    tick = 1; cyc(); tick = 0;
    for (int i = 0; i < 7; i++) begin
      check("wait_req", chk_req, 1);
      check("wait_chk_row", chk_row, 8);
      tick = ~i[0];
      cyc();
    end
    tick = 0; chk_ack = 1; cyc(); chk_ack = 0;
    check("slow_row", row, 8);
    check("slow_req_drop", chk_req, 0);
    cyc(); cyc();
    check("slow_single_step", row, 8);

    // 5: reset mid-handshake with a same-cycle ack
    tick = 1; cyc(); tick = 0;
    check("mid_req", chk_req, 1);
    reset = 1; chk_ack = 1; cyc(); reset = 0; chk_ack = 0;
    check("mid_rst_req", chk_req, 0);
    check("mid_rst_row", row, 0);
    check("mid_rst_active", active, 0);
    check("mid_rst_lock", lock, 0);

    // randomized traffic against the model
    for (int c = 0; c < 15000; c++) begin
      hp = (c < 5000) ? 0 : (c < 10000) ? 15 : 50;
      reset   = m_over ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 499) == 0);
      spawn   = ($urandom_range(0, 7) == 0);
      tick    = ($urandom_range(0, 3) == 0);
      chk_ack = ($urandom_range(0, 2) == 0);
      chk_hit = ($urandom_range(0, 99) < hp);
      cyc();
    end
    reset = 0; spawn = 0; tick = 0; chk_ack = 0; chk_hit = 0;
    cyc();

    // 6: LOCK_TICKS=1 instance
    ak1 = 1; ht1 = 0;
    sp1 = 1; cyc(); sp1 = 0; cyc();
    check("lt1_active", act1, 1);
    ht1 = 1;
    tk1 = 1; cyc(); tk1 = 0;
    check("lt1_req", req1, 1);
    check("lt1_no_early_lock", lock1, 0);
    cyc();
    check("lt1_lock", lock1, 1);
    sp1 = 1; cyc(); sp1 = 0;
    check("lt1_lock_drop", lock1, 0);
    check("lt1_spawn_ignored", req1, 0);
    sp1 = 1; cyc(); sp1 = 0;
    check("lt1_spawn_taken", req1, 1);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
